// File: rtl/pc_pkg.sv
// pc_pkg: shared encodings and defaults for the fetch-PC generator.
//   - NPC_* : 3-bit redirect select encodings (5..7 are illegal)
//   - state_t : exception-level FSM states
//   - DEF_* : default reset PC, interrupt vector and legal fetch window
package pc_pkg;

   localparam logic [2:0] NPC_SEQ     = 3'd0;
   localparam logic [2:0] NPC_BRANCH  = 3'd1;
   localparam logic [2:0] NPC_JUMP    = 3'd2;
   localparam logic [2:0] NPC_JUMPREG = 3'd3;
   localparam logic [2:0] NPC_ERET    = 3'd4;

   typedef enum logic {
      ST_NORMAL  = 1'b0,
      ST_HANDLER = 1'b1
   } state_t;

   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
   localparam logic [31:0] DEF_ADDR_LO    = 32'h0000_3000;
   localparam logic [31:0] DEF_ADDR_HI    = 32'h0000_6ffc;

   // Any encoding above ERET is not a defined redirect.
   function automatic logic selIllegal(input logic [2:0] sel);
      return sel > NPC_ERET;
   endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: groups the D-stage/CP0 control inputs and the fetch-PC outputs.
//   slave  modport : the PC generator (consumes control, drives PC/flags)
//   master modport : the pipeline/CP0 side
// Flow control: there is no valid/ready pair here. i_stall is the only
// back-pressure; while it is high the PC and all flags hold, and any
// interrupt request seen in that cycle is latched until a non-stall edge.
interface pc_gen_if #(parameter int WIDTH = 32) ();
   import pc_pkg::*;

   logic             i_stall;
   logic [2:0]       i_npc_sel;
   logic [WIDTH-1:0] i_pc_d;
   logic [31:0]      i_instr;
   logic [WIDTH-1:0] i_rs;
   logic [WIDTH-1:0] i_epc;
   logic             i_int;

   logic [WIDTH-1:0] o_pc;
   logic [WIDTH-1:0] o_npc;
   logic [WIDTH-1:0] o_pc8;
   logic             o_exl;
   logic             o_adel;
   logic             o_sel_err;
   logic             o_int_taken;
   state_t           dbgState;

   modport slave (
      input  i_stall, i_npc_sel, i_pc_d, i_instr, i_rs, i_epc, i_int,
      output o_pc, o_npc, o_pc8, o_exl, o_adel, o_sel_err, o_int_taken, dbgState
   );

   modport master (
      output i_stall, i_npc_sel, i_pc_d, i_instr, i_rs, i_epc, i_int,
      input  o_pc, o_npc, o_pc8, o_exl, o_adel, o_sel_err, o_int_taken, dbgState
   );

endinterface

// File: rtl/pc_gen_npc_target.sv
// npc_target: purely combinational candidate next-PC selection.
//   pc      : current fetch PC (SEQ base, and hold value for illegal selects)
//   npcSel  : redirect select
//   pcD     : PC of the D-stage control-transfer instruction
//   instr   : D-stage instruction (imm16 / index26)
//   rs, epc : JUMPREG / ERET targets
//   target  : candidate next PC (no interrupt override applied here)
module npc_target
   import pc_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int BR_PLUS4 = 1
) (
   input  logic [WIDTH-1:0] pc,
   input  logic [2:0]       npcSel,
   input  logic [WIDTH-1:0] pcD,
   input  logic [31:0]      instr,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] target
);

   logic [WIDTH-1:0] brBase;
   logic [WIDTH-1:0] brOff;
   logic [WIDTH-1:0] jmpTgt;

   always_comb begin
      brBase = (BR_PLUS4 != 0) ? pcD + WIDTH'(4) : pcD;
      // Word offset: sign-extended imm16 shifted left by two.
      brOff  = {{(WIDTH-18){instr[15]}}, instr[15:0], 2'b00};
      // Region bits above the 256 MB index window come from the D-stage PC.
      jmpTgt = {pcD[WIDTH-1:28], instr[25:0], 2'b00};

      target = pc;
      case (npcSel)
         NPC_SEQ:     target = pc + WIDTH'(4);
         NPC_BRANCH:  target = brBase + brOff;
         NPC_JUMP:    target = jmpTgt;
         NPC_JUMPREG: target = rs;
         NPC_ERET:    target = epc;
         default:     target = pc;
      endcase
   end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-PC generator for the F stage.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : pc_gen_if slave modport carrying stall, redirect select,
//                D-stage PC/instruction/rs, CP0 EPC and interrupt request in;
//                registered PC, combinational next-PC and link value, and
//                the exl / adel / sel_err / int_taken flags out.
// Holds the PC register, the pending-interrupt latch, the NORMAL/HANDLER
// exception-level FSM and the registered status flags.
module pc_gen
   import pc_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEF_RESET_PC),
   parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR),
   parameter logic [WIDTH-1:0] ADDR_LO    = WIDTH'(DEF_ADDR_LO),
   parameter logic [WIDTH-1:0] ADDR_HI    = WIDTH'(DEF_ADDR_HI),
   parameter int               BR_PLUS4   = 1
) (
   input logic      clk,
   input logic      reset,
   pc_gen_if.slave  bus
);

   state_t           stateQ, stateNext;
   logic [WIDTH-1:0] pcQ, pcNext;
   logic             pendQ, pendNext;
   logic             adelQ, adelNext;
   logic             selErrQ, selErrNext;
   logic             intTakenQ, intTakenNext;
   logic [WIDTH-1:0] target;
   logic             exl;
   logic             intReq;

   function automatic logic badAddr(input logic [WIDTH-1:0] a);
      return (a[1:0] != 2'b00) || (a < ADDR_LO) || (a > ADDR_HI);
   endfunction

   npc_target #(
      .WIDTH    (WIDTH),
      .BR_PLUS4 (BR_PLUS4)
   ) u_target (
      .pc     (pcQ),
      .npcSel (bus.i_npc_sel),
      .pcD    (bus.i_pc_d),
      .instr  (bus.i_instr),
      .rs     (bus.i_rs),
      .epc    (bus.i_epc),
      .target (target)
   );

   assign exl = (stateQ == ST_HANDLER);
   // Interrupts are masked entirely while in the handler: neither taken
   // nor latched, so a pulse arriving then is simply lost.
   assign intReq = (bus.i_int | pendQ) & ~exl;

   always_comb begin
      stateNext    = stateQ;
      pcNext       = pcQ;
      pendNext     = pendQ;
      adelNext     = adelQ;
      selErrNext   = selErrQ;
      intTakenNext = 1'b0;

      if (intReq && !bus.i_stall) begin
         // Interrupt beats any redirect on the same edge, including ERET
         // (which can only coincide here when exl is already 0).
         pcNext       = EXC_VECTOR;
         stateNext    = ST_HANDLER;
         pendNext     = 1'b0;
         intTakenNext = 1'b1;
         adelNext     = badAddr(EXC_VECTOR);
      end else if (intReq) begin
         pendNext = 1'b1;
      end else if (!bus.i_stall) begin
         pcNext     = target;
         adelNext   = badAddr(target);
         selErrNext = selIllegal(bus.i_npc_sel);
         if (bus.i_npc_sel == NPC_ERET && stateQ == ST_HANDLER) begin
            stateNext = ST_NORMAL;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateQ    <= ST_NORMAL;
         pcQ       <= RESET_PC;
         pendQ     <= 1'b0;
         adelQ     <= 1'b0;
         selErrQ   <= 1'b0;
         intTakenQ <= 1'b0;
      end else begin
         stateQ    <= stateNext;
         pcQ       <= pcNext;
         pendQ     <= pendNext;
         adelQ     <= adelNext;
         selErrQ   <= selErrNext;
         intTakenQ <= intTakenNext;
      end
   end

   assign bus.o_pc        = pcQ;
   assign bus.o_npc       = intReq ? EXC_VECTOR : target;
   assign bus.o_pc8       = pcQ + WIDTH'(8);
   assign bus.o_exl       = exl;
   assign bus.o_adel      = adelQ;
   assign bus.o_sel_err   = selErrQ;
   assign bus.o_int_taken = intTakenQ;
   assign bus.dbgState    = stateQ;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed, table-driven bench for pc_gen. A second instance
// built with BR_PLUS4=0 shares every input with the main instance so the
// alternate branch base can be observed on the same stimulus.
module tb_pc_gen;
   import pc_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   nChecks = 0;
   int   nMiscompares = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   pc_gen_if #(.WIDTH(32)) bus  ();
   pc_gen_if #(.WIDTH(32)) bus0 ();

   assign bus0.i_stall   = bus.i_stall;
   assign bus0.i_npc_sel = bus.i_npc_sel;
   assign bus0.i_pc_d    = bus.i_pc_d;
   assign bus0.i_instr   = bus.i_instr;
   assign bus0.i_rs      = bus.i_rs;
   assign bus0.i_epc     = bus.i_epc;
   assign bus0.i_int     = bus.i_int;

   pc_gen #(.WIDTH(32), .BR_PLUS4(1)) dut  (.clk(clk), .reset(reset), .bus(bus));
   pc_gen #(.WIDTH(32), .BR_PLUS4(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

   typedef struct {
      logic [2:0]  sel;
      logic        stall;
      logic [31:0] pcD;
      logic [31:0] instr;
      logic [31:0] rs;
      logic [31:0] epc;
      logic [31:0] expPc;
      logic        expAdel;
      logic        expSelErr;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(input logic [2:0] sel, input logic stall,
                               input logic [31:0] pcD, input logic [31:0] instr,
                               input logic [31:0] rs, input logic [31:0] epc,
                               input logic [31:0] expPc, input logic expAdel,
                               input logic expSelErr);
      vec_t v;
      v.sel = sel; v.stall = stall; v.pcD = pcD; v.instr = instr;
      v.rs = rs; v.epc = epc; v.expPc = expPc; v.expAdel = expAdel;
      v.expSelErr = expSelErr;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] sel, input logic stall, input logic intr,
                        input logic [31:0] pcD, input logic [31:0] instr,
                        input logic [31:0] rs, input logic [31:0] epc);
      bus.i_npc_sel = sel;
      bus.i_stall   = stall;
      bus.i_int     = intr;
      bus.i_pc_d    = pcD;
      bus.i_instr   = instr;
      bus.i_rs      = rs;
      bus.i_epc     = epc;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nMiscompares++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   initial begin
      logic [31:0] expPc;

      vecs[0]  = mk(NPC_SEQ,     1'b0, 32'h0,    32'h0,         32'h0,         32'h0,    32'h3004,      1'b0, 1'b0);
      vecs[1]  = mk(NPC_SEQ,     1'b0, 32'h0,    32'h0,         32'h0,         32'h0,    32'h3008,      1'b0, 1'b0);
      vecs[2]  = mk(NPC_SEQ,     1'b0, 32'h0,    32'h0,         32'h0,         32'h0,    32'h300c,      1'b0, 1'b0);
      vecs[3]  = mk(NPC_BRANCH,  1'b0, 32'h3010, 32'h1000_fffe, 32'h0,         32'h0,    32'h300c,      1'b0, 1'b0);
      vecs[4]  = mk(NPC_JUMP,    1'b0, 32'h3010, 32'h0800_0c40, 32'h0,         32'h0,    32'h3100,      1'b0, 1'b0);
      vecs[5]  = mk(NPC_JUMPREG, 1'b0, 32'h0,    32'h0,         32'h3002,      32'h0,    32'h3002,      1'b1, 1'b0);
      vecs[6]  = mk(NPC_JUMPREG, 1'b0, 32'h0,    32'h0,         32'h7000,      32'h0,    32'h7000,      1'b1, 1'b0);
      vecs[7]  = mk(NPC_JUMPREG, 1'b0, 32'h0,    32'h0,         32'h6ffc,      32'h0,    32'h6ffc,      1'b0, 1'b0);
      vecs[8]  = mk(NPC_JUMPREG, 1'b0, 32'h0,    32'h0,         32'h2ffc,      32'h0,    32'h2ffc,      1'b1, 1'b0);
      vecs[9]  = mk(NPC_JUMPREG, 1'b0, 32'h0,    32'h0,         32'hffff_fffc, 32'h0,    32'hffff_fffc, 1'b1, 1'b0);
      vecs[10] = mk(NPC_SEQ,     1'b0, 32'h0,    32'h0,         32'h0,         32'h0,    32'h0,         1'b1, 1'b0);
      vecs[11] = mk(NPC_JUMPREG, 1'b0, 32'h0,    32'h0,         32'h3004,      32'h0,    32'h3004,      1'b0, 1'b0);
      vecs[12] = mk(NPC_SEQ,     1'b0, 32'h0,    32'h0,         32'h0,         32'h0,    32'h3008,      1'b0, 1'b0);
      vecs[13] = mk(3'd6,        1'b0, 32'h0,    32'h0,         32'h0,         32'h0,    32'h3008,      1'b0, 1'b1);
      vecs[14] = mk(NPC_SEQ,     1'b0, 32'h0,    32'h0,         32'h0,         32'h0,    32'h300c,      1'b0, 1'b0);
      vecs[15] = mk(NPC_ERET,    1'b0, 32'h0,    32'h0,         32'h0,         32'h3020, 32'h3020,      1'b0, 1'b0);
      vecs[16] = mk(NPC_SEQ,     1'b1, 32'h0,    32'h0,         32'h0,         32'h0,    32'h3020,      1'b0, 1'b0);
      vecs[17] = mk(NPC_SEQ,     1'b0, 32'h0,    32'h0,         32'h0,         32'h0,    32'h3024,      1'b0, 1'b0);

      // Clock/reset
      reset = 1'b1;
      drive(NPC_SEQ, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc",        bus.o_pc,        32'h3000);
      check("rst_npc",       bus.o_npc,       32'h3004);
      check("rst_pc8",       bus.o_pc8,       32'h3008);
      check("rst_exl",       32'(bus.o_exl),       32'h0);
      check("rst_adel",      32'(bus.o_adel),      32'h0);
      check("rst_sel_err",   32'(bus.o_sel_err),   32'h0);
      check("rst_int_taken", 32'(bus.o_int_taken), 32'h0);
      reset = 1'b0;

      // Table-driven redirect / range / select vectors
      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].sel, vecs[i].stall, 1'b0, vecs[i].pcD, vecs[i].instr,
               vecs[i].rs, vecs[i].epc);
         exp_q.push_back(vecs[i].expPc);
         tick();
         expPc = exp_q.pop_front();
         check($sformatf("v%0d_pc", i),       bus.o_pc,  expPc);
         check($sformatf("v%0d_pc8", i),      bus.o_pc8, expPc + 32'd8);
         check($sformatf("v%0d_adel", i),     32'(bus.o_adel),      32'(vecs[i].expAdel));
         check($sformatf("v%0d_sel_err", i),  32'(bus.o_sel_err),   32'(vecs[i].expSelErr));
         check($sformatf("v%0d_exl", i),      32'(bus.o_exl),       32'h0);
         check($sformatf("v%0d_int_taken", i), 32'(bus.o_int_taken), 32'h0);
         if (i == 3) check("br_plus4_0_pc", bus0.o_pc, 32'h3008);
      end

      // Interrupt during stall: held, then latched, then taken
      drive(NPC_SEQ, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
      #1;
      check("stint_npc", bus.o_npc, 32'h4180);
      tick();
      check("stint1_pc",  bus.o_pc, 32'h3024);
      check("stint1_it",  32'(bus.o_int_taken), 32'h0);
      bus.i_int = 1'b0;
      #1;
      check("pend_npc", bus.o_npc, 32'h4180);
      tick();
      check("stint2_pc",  bus.o_pc, 32'h3024);
      check("stint2_exl", 32'(bus.o_exl), 32'h0);
      bus.i_stall = 1'b0;
      tick();
      check("take_pc",   bus.o_pc, 32'h4180);
      check("take_it",   32'(bus.o_int_taken), 32'h1);
      check("take_exl",  32'(bus.o_exl), 32'h1);
      check("take_adel", 32'(bus.o_adel), 32'h0);

      // Second interrupt in handler is ignored and not latched
      drive(NPC_SEQ, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
      #1;
      check("hnd_npc", bus.o_npc, 32'h4184);
      tick();
      check("hnd_pc",  bus.o_pc, 32'h4184);
      check("hnd_it",  32'(bus.o_int_taken), 32'h0);
      check("hnd_exl", 32'(bus.o_exl), 32'h1);

      // ERET together with an interrupt while exl=1: ERET proceeds
      drive(NPC_ERET, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h3020);
      tick();
      check("eret_pc",  bus.o_pc, 32'h3020);
      check("eret_exl", 32'(bus.o_exl), 32'h0);
      check("eret_it",  32'(bus.o_int_taken), 32'h0);
      drive(NPC_SEQ, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      tick();
      check("post_eret_pc",  bus.o_pc, 32'h3024);
      check("post_eret_exl", 32'(bus.o_exl), 32'h0);

      // Later interrupt coinciding with a branch: interrupt wins
      drive(NPC_BRANCH, 1'b0, 1'b1, 32'h3010, 32'h1000_fffe, 32'h0, 32'h0);
      tick();
      check("intbr_pc",  bus.o_pc, 32'h4180);
      check("intbr_it",  32'(bus.o_int_taken), 32'h1);
      check("intbr_exl", 32'(bus.o_exl), 32'h1);
      drive(NPC_SEQ, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      tick();
      check("pulse_pc", bus.o_pc, 32'h4184);
      check("pulse_it", 32'(bus.o_int_taken), 32'h0);
      drive(NPC_ERET, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h3040);
      tick();
      check("eret2_pc",  bus.o_pc, 32'h3040);
      check("eret2_exl", 32'(bus.o_exl), 32'h0);

      // Reset mid-stall with an interrupt pending: pending is lost
      drive(NPC_SEQ, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
      tick();
      check("prerst_pc", bus.o_pc, 32'h3040);
      bus.i_int = 1'b0;
      reset = 1'b1;
      #2;
      check("asyncrst_pc",  bus.o_pc, 32'h3000);
      check("asyncrst_npc", bus.o_npc, 32'h3004);
      reset = 1'b0;
      bus.i_stall = 1'b0;
      tick();
      check("lost_pc",  bus.o_pc, 32'h3004);
      check("lost_it",  32'(bus.o_int_taken), 32'h0);
      check("lost_exl", 32'(bus.o_exl), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiscompares);
      $finish;
   end

endmodule
